// File: rtl/keydriver_if.sv
`default_nettype none
// ============================================================================
//  Module      : keydriver_if
//  Description : CPU-side register bus of the key/switch input peripheral.
//                The master is the processor; the slave is keydriver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keydriver_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output irq
  );
endinterface
`default_nettype wire

// File: rtl/keydriver.sv
`default_nettype none
// ============================================================================
//  Module      : keydriver
//  Description : Memory-mapped input peripheral. Synchronizes and debounces
//                4 active-low push-buttons and 10 slide switches, exposes
//                them as read-only registers, latches key presses in a
//                write-1-to-clear edge-capture register and drives a
//                maskable level interrupt.
//                  addr 0 : switches   (RO)  [9:0]
//                  addr 1 : keys       (RO)  [3:0], pressed = 1
//                  addr 2 : edgecapture (W1C) [3:0]
//                  addr 3 : irqmask    (RW)  [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module keydriver #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  keydriver_if.slave bus,
  input  logic [3:0] KEY,
  input  logic [9:0] SW
);

  // Channel layout: [3:0] keys (pressed = 1), [13:4] switches.
  localparam int c_NCHAN = 14;
  localparam int c_CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_ADDR_SW   = 2'd0;
  localparam logic [1:0] c_ADDR_KEY  = 2'd1;
  localparam logic [1:0] c_ADDR_EDGE = 2'd2;
  localparam logic [1:0] c_ADDR_MASK = 2'd3;

  logic [c_NCHAN-1:0] w_raw;      // pins, keys inverted so that pressed = 1
  logic [c_NCHAN-1:0] w_deb;      // current debounced levels
  logic [c_NCHAN-1:0] w_deb_nxt;  // debounced levels after this edge

  logic [3:0]  r_edge;
  logic [3:0]  r_mask;
  logic [31:0] r_rdata;

  logic [3:0]  w_key_rise;
  logic [3:0]  w_edge_clr;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  assign w_raw = {SW, ~KEY};

  // --------------------------------------------------------------------------
  // Per-channel synchronizer and debouncer. Every channel is independent so a
  // bouncing key never disturbs the qualification of any other input.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < c_NCHAN; i++) begin : g_chan
      logic            r_meta;
      logic            r_sync;
      logic            r_d;
      logic [c_CW-1:0] r_cnt;
      logic            w_d_nxt;
      logic [c_CW-1:0] w_cnt_nxt;

      // Two-flop synchronizer for the asynchronous pin.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= w_raw[i];
          r_sync <= r_meta;
        end
      end

      // Accept a new level only after it has been stable for the full window.
      always_comb begin
        w_d_nxt   = r_d;
        w_cnt_nxt = r_cnt;
        if (r_sync == r_d) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_MAX) begin
          w_d_nxt   = r_sync;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Debounced level and stability counter.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_d   <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_d   <= w_d_nxt;
          r_cnt <= w_cnt_nxt;
        end
      end

      assign w_deb[i]     = r_d;
      assign w_deb_nxt[i] = w_d_nxt;
    end
  endgenerate

  // A press is seen on the very edge the debounced key level rises, so the
  // capture bit and the debounced level become visible together.
  assign w_key_rise = w_deb_nxt[3:0] & ~w_deb[3:0];

  assign w_edge_clr = (bus.write && (bus.address == c_ADDR_EDGE)) ?
                      bus.writedata[3:0] : 4'h0;

  // Edge capture: clear-by-write-1, with a simultaneous new press taking priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= 4'h0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_key_rise;
    end
  end

  // Interrupt mask, fully overwritten by a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= 4'h0;
    end else if (bus.write && (bus.address == c_ADDR_MASK)) begin
      r_mask <= bus.writedata[3:0];
    end
  end

  // Read mux over the current register values, so a same-cycle write is not
  // reflected in the returned data.
  always_comb begin
    w_rdata = 32'h0;
    case (bus.address)
      c_ADDR_SW:   w_rdata[9:0] = w_deb[13:4];
      c_ADDR_KEY:  w_rdata[3:0] = w_deb[3:0];
      c_ADDR_EDGE: w_rdata[3:0] = r_edge;
      c_ADDR_MASK: w_rdata[3:0] = r_mask;
      default:     w_rdata      = 32'h0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'h0;
    end else if (bus.read) begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.readdata = r_rdata;
  assign bus.irq      = |(r_edge & r_mask);

  // Only the low nibble of the write data is meaningful.
  assign w_unused_wdata = &{1'b0, bus.writedata[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_keydriver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keydriver
//  Description : Directed self-checking bench for keydriver, run with a
//                short debounce window of 4 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keydriver;

  localparam int DEB = 4;

  logic       clk;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;

  int n_checks;
  int n_fail;

  keydriver_if bus ();

  keydriver #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .KEY   (KEY),
    .SW    (SW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 500000");
    $fatal(1, "watchdog");
  end

  // Bus access helpers (stimulus only).
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    d = bus.readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = v;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_readdata: got %h expected 00000000", bus.readdata);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read_addr%0d: got %h expected 00000000", a, d);
      end
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", bus.irq);
    end
  endtask

  task automatic test_switches;
    logic [31:0] d;
    @(negedge clk);
    SW = 10'h2A5;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (dut.w_deb[13:4] !== 10'h000) begin
      n_fail++;
      $display("FAIL sw_edge5: got %h expected 000", dut.w_deb[13:4]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.w_deb[13:4] !== 10'h2A5) begin
      n_fail++;
      $display("FAIL sw_edge6: got %h expected 2a5", dut.w_deb[13:4]);
    end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_02A5) begin
      n_fail++;
      $display("FAIL sw_read: got %h expected 000002a5", d);
    end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_02A5) begin
      n_fail++;
      $display("FAIL sw_write_ignored: got %h expected 000002a5", d);
    end
  endtask

  task automatic test_key_glitch;
    logic [31:0] d;
    @(negedge clk);
    KEY[1] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_keys: got %h expected 00000000", d);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_edge: got %h expected 00000000", d);
    end
    @(negedge clk);
    KEY[1] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL press_keys: got %h expected 00000002", d);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL press_edge: got %h expected 00000002", d);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL press_irq_masked: got %b expected 0", bus.irq);
    end
    KEY[1] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL release_keys: got %h expected 00000000", d);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL release_edge: got %h expected 00000002", d);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bus_write(2'd3, 32'h2);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_unmasked: got %b expected 1", bus.irq);
    end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL irq_mask_read: got %h expected 00000002", d);
    end
    bus_write(2'd2, 32'h1);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_wrong_clear: got %b expected 1", bus.irq);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL edge_wrong_clear: got %h expected 00000002", d);
    end
    bus_write(2'd2, 32'h2);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_cleared: got %b expected 0", bus.irq);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL edge_cleared: got %h expected 00000000", d);
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    @(negedge clk);
    KEY[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.address   = 2'd2;
    bus.writedata = 32'h1;
    bus.write     = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.w_deb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL setwins_coincide: got %b expected 1", dut.w_deb[0]);
    end
    @(negedge clk);
    bus.write = 1'b0;
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL setwins_edge: got %h expected 00000001", d);
    end
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fail++;
      $display("FAIL setwins_irq: got %b expected 1", bus.irq);
    end
    KEY[0] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bus_read(2'd0, d);
    @(negedge clk);
    SW = 10'h0F0;
    repeat (4) @(posedge clk);
    #3;
    n_checks++;
    if (dut.g_chan[8].r_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL arst_precount: got %0d expected 2", dut.g_chan[8].r_cnt);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut.g_chan[8].r_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_count: got %0d expected 0", dut.g_chan[8].r_cnt);
    end
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_readdata: got %h expected 00000000", bus.readdata);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_irq: got %b expected 0", bus.irq);
    end
    n_checks++;
    if (dut.w_deb !== 14'h0) begin
      n_fail++;
      $display("FAIL arst_deb: got %h expected 0000", dut.w_deb);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (dut.w_deb[13:4] !== 10'h000) begin
      n_fail++;
      $display("FAIL arst_requal_early: got %h expected 000", dut.w_deb[13:4]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.w_deb[13:4] !== 10'h0F0) begin
      n_fail++;
      $display("FAIL arst_requal: got %h expected 0f0", dut.w_deb[13:4]);
    end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_mask: got %h expected 00000000", d);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    KEY           = 4'hF;
    SW            = 10'h000;
    bus.address   = 2'd0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_switches();
    test_key_glitch();
    test_irq();
    test_set_wins();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
